// File: rtl/alarm_clock_pkg.sv
// alarm_clock_pkg
// Shared definitions for the multi-alarm clock: the ring FSM state type,
// the time-field limits and a helper that adds minutes to an hh:mm value
// with hour and midnight wrap.
package alarm_clock_pkg;

    // Ring controller states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RINGING = 2'd1,
        ST_SNOOZE  = 2'd2
    } ring_state_t;

    localparam int MAX_HOUR = 23;
    localparam int MAX_MIN  = 59;
    localparam int MAX_SEC  = 59;

    // Returns {hours[4:0], minutes[5:0]} of hh:mm + add_min.
    // Both mm and add_min are at most 59, so a single carry is enough.
    function automatic logic [10:0] add_minutes(input logic [4:0] hh,
                                                input logic [5:0] mm,
                                                input logic [5:0] add_min);
        logic [6:0] min_sum;
        logic [5:0] hour_sum;
        logic [4:0] hour_out;
        logic [5:0] min_out;
        min_sum = {1'b0, mm} + {1'b0, add_min};
        if (min_sum > 7'(MAX_MIN)) begin
            min_out  = 6'(min_sum - 7'd60);
            hour_sum = {1'b0, hh} + 6'd1;
        end else begin
            min_out  = min_sum[5:0];
            hour_sum = {1'b0, hh};
        end
        if (hour_sum > 6'(MAX_HOUR)) begin
            hour_out = 5'(hour_sum - 6'd24);
        end else begin
            hour_out = hour_sum[4:0];
        end
        return {hour_out, min_out};
    endfunction

endpackage

// File: rtl/alarm_clock_multi_hms_counter.sv
// hms_counter
// Prescaler plus 24-hour HH:MM:SS time base with a validated load.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   ena                        prescaler enable (time freezes when low)
//   set_valid, set_*           time load; ignored if any field out of range
//   hours, minutes, seconds    registered current time
//   tick                       registered pulse coincident with new time
//   advance                    combinational: time advances at this edge
//   next_hours/minutes/seconds combinational time after one advance
module hms_counter
    import alarm_clock_pkg::*;
#(
    parameter int CLK_DIV = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       set_valid,
    input  logic [4:0] set_hours,
    input  logic [5:0] set_minutes,
    input  logic [5:0] set_seconds,
    output logic [4:0] hours,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic       tick,
    output logic       advance,
    output logic [4:0] next_hours,
    output logic [5:0] next_minutes,
    output logic [5:0] next_seconds
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [PW-1:0] prescale;
    logic          load_ok;

    // An invalid load is treated as if set_valid were low, so the
    // prescaler keeps running and the advance may still happen.
    assign load_ok = set_valid
                  && (set_hours   <= 5'(MAX_HOUR))
                  && (set_minutes <= 6'(MAX_MIN))
                  && (set_seconds <= 6'(MAX_SEC));

    assign advance = !load_ok && ena && (prescale == PW'(CLK_DIV - 1));

    // Time value one second ahead, with seconds/minutes/day carries.
    always_comb begin
        next_hours   = hours;
        next_minutes = minutes;
        next_seconds = seconds + 6'd1;
        if (seconds == 6'(MAX_SEC)) begin
            next_seconds = '0;
            next_minutes = minutes + 6'd1;
            if (minutes == 6'(MAX_MIN)) begin
                next_minutes = '0;
                next_hours   = (hours == 5'(MAX_HOUR)) ? 5'd0 : hours + 5'd1;
            end
        end
    end

    // Prescaler, time registers and tick. A valid load wins over the
    // advance, restarts the second and suppresses the tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescale <= '0;
            hours    <= '0;
            minutes  <= '0;
            seconds  <= '0;
            tick     <= 1'b0;
        end else if (load_ok) begin
            prescale <= '0;
            hours    <= set_hours;
            minutes  <= set_minutes;
            seconds  <= set_seconds;
            tick     <= 1'b0;
        end else begin
            tick <= advance;
            if (ena) begin
                if (prescale == PW'(CLK_DIV - 1)) begin
                    prescale <= '0;
                    hours    <= next_hours;
                    minutes  <= next_minutes;
                    seconds  <= next_seconds;
                end else begin
                    prescale <= prescale + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/alarm_clock_multi.sv
// alarm_clock_multi
// 24-hour clock with NUM_ALARMS programmable alarm slots and a ring
// controller supporting acknowledge, snooze and auto-timeout.
// Ports:
//   clk, rst_n             clock, async active-low reset
//   ena                    time base enable
//   set_valid, set_*       load current time (validated)
//   alm_wr, alm_idx,
//   alm_hours/minutes/en   write one alarm slot (validated)
//   ack, snooze            user controls for the ring controller
//   hours/minutes/seconds  current time
//   tick                   one-cycle pulse with each new second
//   alarm, snoozing        ring controller in RINGING / SNOOZE
//   alarm_id               slot responsible for the current ring/snooze
module alarm_clock_multi
    import alarm_clock_pkg::*;
#(
    parameter int CLK_DIV        = 10,
    parameter int NUM_ALARMS     = 4,
    parameter int SNOOZE_MIN     = 5,
    parameter int RING_TIMEOUT_S = 60,
    localparam int IW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ena,
    input  logic          set_valid,
    input  logic [4:0]    set_hours,
    input  logic [5:0]    set_minutes,
    input  logic [5:0]    set_seconds,
    input  logic          alm_wr,
    input  logic [IW-1:0] alm_idx,
    input  logic [4:0]    alm_hours,
    input  logic [5:0]    alm_minutes,
    input  logic          alm_en,
    input  logic          ack,
    input  logic          snooze,
    output logic [4:0]    hours,
    output logic [5:0]    minutes,
    output logic [5:0]    seconds,
    output logic          tick,
    output logic          alarm,
    output logic [IW-1:0] alarm_id,
    output logic          snoozing
);

    localparam int RW = $clog2(RING_TIMEOUT_S + 1);

    logic       advance;
    logic [4:0] next_hours;
    logic [5:0] next_minutes;
    logic [5:0] next_seconds;

    hms_counter #(
        .CLK_DIV(CLK_DIV)
    ) u_hms (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .set_valid   (set_valid),
        .set_hours   (set_hours),
        .set_minutes (set_minutes),
        .set_seconds (set_seconds),
        .hours       (hours),
        .minutes     (minutes),
        .seconds     (seconds),
        .tick        (tick),
        .advance     (advance),
        .next_hours  (next_hours),
        .next_minutes(next_minutes),
        .next_seconds(next_seconds)
    );

    logic [4:0] slot_hours   [NUM_ALARMS];
    logic [5:0] slot_minutes [NUM_ALARMS];
    logic       slot_en      [NUM_ALARMS];
    logic       wr_ok;

    assign wr_ok = alm_wr
                && (int'(alm_idx) < NUM_ALARMS)
                && (alm_hours   <= 5'(MAX_HOUR))
                && (alm_minutes <= 6'(MAX_MIN));

    // Alarm slot storage; slots are independent of the ring controller.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                slot_hours[i]   <= '0;
                slot_minutes[i] <= '0;
                slot_en[i]      <= 1'b0;
            end
        end else if (wr_ok) begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                if (int'(alm_idx) == i) begin
                    slot_hours[i]   <= alm_hours;
                    slot_minutes[i] <= alm_minutes;
                    slot_en[i]      <= alm_en;
                end
            end
        end
    end

    logic          match_hit;
    logic [IW-1:0] match_id;

    // Compare every enabled slot against the upcoming hh:mm. Scanning
    // downward lets the lowest matching index overwrite the others.
    always_comb begin
        match_hit = 1'b0;
        match_id  = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (slot_en[i] && (slot_hours[i] == next_hours)
                           && (slot_minutes[i] == next_minutes)) begin
                match_hit = 1'b1;
                match_id  = IW'(i);
            end
        end
    end

    ring_state_t   state, state_next;
    logic [RW-1:0] ring_cnt, ring_cnt_next;
    logic [4:0]    target_hours, target_hours_next;
    logic [5:0]    target_minutes, target_minutes_next;
    logic [IW-1:0] alarm_id_next;
    logic [10:0]   snooze_hm;
    logic          minute_edge;

    assign snooze_hm   = add_minutes(hours, minutes, 6'(SNOOZE_MIN));
    assign minute_edge = advance && (next_seconds == 6'd0);

    // Ring controller next-state logic. ack always dominates snooze, and
    // matches are only considered from IDLE so they are never queued.
    always_comb begin
        state_next          = state;
        ring_cnt_next       = ring_cnt;
        target_hours_next   = target_hours;
        target_minutes_next = target_minutes;
        alarm_id_next       = alarm_id;
        case (state)
            ST_IDLE: begin
                if (minute_edge && match_hit) begin
                    state_next    = ST_RINGING;
                    alarm_id_next = match_id;
                    ring_cnt_next = '0;
                end
            end
            ST_RINGING: begin
                if (ack) begin
                    state_next = ST_IDLE;
                end else if (snooze) begin
                    state_next          = ST_SNOOZE;
                    target_hours_next   = snooze_hm[10:6];
                    target_minutes_next = snooze_hm[5:0];
                end else if (advance) begin
                    if (ring_cnt == RW'(RING_TIMEOUT_S - 1)) begin
                        state_next = ST_IDLE;
                    end else begin
                        ring_cnt_next = ring_cnt + 1'b1;
                    end
                end
            end
            ST_SNOOZE: begin
                if (ack) begin
                    state_next = ST_IDLE;
                end else if (minute_edge && (next_hours == target_hours)
                                         && (next_minutes == target_minutes)) begin
                    state_next    = ST_RINGING;
                    ring_cnt_next = '0;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State register; alarm/snoozing are registered decodes of the
    // next state so they line up with the state itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            ring_cnt       <= '0;
            target_hours   <= '0;
            target_minutes <= '0;
            alarm_id       <= '0;
            alarm          <= 1'b0;
            snoozing       <= 1'b0;
        end else begin
            state          <= state_next;
            ring_cnt       <= ring_cnt_next;
            target_hours   <= target_hours_next;
            target_minutes <= target_minutes_next;
            alarm_id       <= alarm_id_next;
            alarm          <= (state_next == ST_RINGING);
            snoozing       <= (state_next == ST_SNOOZE);
        end
    end

endmodule

// File: tb/tb_alarm_clock_multi.sv
// tb_alarm_clock_multi
// Directed scenarios followed by a randomized phase, all checked every
// cycle against a behavioural model that keeps time as seconds-of-day
// and alarm/snooze times as minutes-of-day.
module tb_alarm_clock_multi;

    localparam int CLK_DIV        = 4;
    localparam int NUM_ALARMS     = 4;
    localparam int SNOOZE_MIN     = 5;
    localparam int RING_TIMEOUT_S = 3;
    localparam int IW             = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ena = 1'b0;
    logic          set_valid = 1'b0;
    logic [4:0]    set_hours = '0;
    logic [5:0]    set_minutes = '0;
    logic [5:0]    set_seconds = '0;
    logic          alm_wr = 1'b0;
    logic [IW-1:0] alm_idx = '0;
    logic [4:0]    alm_hours = '0;
    logic [5:0]    alm_minutes = '0;
    logic          alm_en = 1'b0;
    logic          ack = 1'b0;
    logic          snooze = 1'b0;
    logic [4:0]    hours;
    logic [5:0]    minutes;
    logic [5:0]    seconds;
    logic          tick;
    logic          alarm;
    logic [IW-1:0] alarm_id;
    logic          snoozing;

    alarm_clock_multi #(
        .CLK_DIV       (CLK_DIV),
        .NUM_ALARMS    (NUM_ALARMS),
        .SNOOZE_MIN    (SNOOZE_MIN),
        .RING_TIMEOUT_S(RING_TIMEOUT_S)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .set_valid  (set_valid),
        .set_hours  (set_hours),
        .set_minutes(set_minutes),
        .set_seconds(set_seconds),
        .alm_wr     (alm_wr),
        .alm_idx    (alm_idx),
        .alm_hours  (alm_hours),
        .alm_minutes(alm_minutes),
        .alm_en     (alm_en),
        .ack        (ack),
        .snooze     (snooze),
        .hours      (hours),
        .minutes    (minutes),
        .seconds    (seconds),
        .tick       (tick),
        .alarm      (alarm),
        .alarm_id   (alarm_id),
        .snoozing   (snoozing)
    );

    always #5 clk = ~clk;

    // Reference model state (0 = idle, 1 = ringing, 2 = snoozing)
    int m_time, m_pre, m_state, m_id, m_cnt, m_target, m_tick;
    int slot_hm [NUM_ALARMS];
    bit slot_on [NUM_ALARMS];

    int checks = 0;
    int fails  = 0;
    int tick_seen;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic modelReset();
        m_time = 0; m_pre = 0; m_state = 0; m_id = 0; m_cnt = 0;
        m_target = 0; m_tick = 0;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            slot_hm[i] = 0;
            slot_on[i] = 1'b0;
        end
    endtask

    // One clock edge of the specification's rules, from the inputs
    // currently applied.
    task automatic modelStep();
        int  nt;
        int  cur_min;
        bit  adv;
        bit  found;
        adv     = 1'b0;
        cur_min = m_time / 60;
        nt      = m_time;
        if (set_valid && set_hours <= 23 && set_minutes <= 59 && set_seconds <= 59) begin
            nt    = set_hours * 3600 + set_minutes * 60 + set_seconds;
            m_pre = 0;
        end else if (ena) begin
            if (m_pre == CLK_DIV - 1) begin
                m_pre = 0;
                adv   = 1'b1;
                nt    = (m_time + 1) % 86400;
            end else begin
                m_pre++;
            end
        end
        case (m_state)
            0: begin
                if (adv && nt % 60 == 0) begin
                    found = 1'b0;
                    for (int i = 0; i < NUM_ALARMS; i++) begin
                        if (!found && slot_on[i] && slot_hm[i] == nt / 60) begin
                            found   = 1'b1;
                            m_state = 1;
                            m_id    = i;
                            m_cnt   = 0;
                        end
                    end
                end
            end
            1: begin
                if (ack) m_state = 0;
                else if (snooze) begin
                    m_state  = 2;
                    m_target = (cur_min + SNOOZE_MIN) % 1440;
                end else if (adv) begin
                    m_cnt++;
                    if (m_cnt >= RING_TIMEOUT_S) m_state = 0;
                end
            end
            default: begin
                if (ack) m_state = 0;
                else if (adv && nt == m_target * 60) begin
                    m_state = 1;
                    m_cnt   = 0;
                end
            end
        endcase
        if (alm_wr && alm_idx < NUM_ALARMS && alm_hours <= 23 && alm_minutes <= 59) begin
            slot_hm[alm_idx] = alm_hours * 60 + alm_minutes;
            slot_on[alm_idx] = alm_en;
        end
        m_time = nt;
        m_tick = adv;
    endtask

    task automatic checkOutput();
        check("hours",    16'(hours),    16'(m_time / 3600));
        check("minutes",  16'(minutes),  16'((m_time / 60) % 60));
        check("seconds",  16'(seconds),  16'(m_time % 60));
        check("tick",     16'(tick),     16'(m_tick));
        check("alarm",    16'(alarm),    16'(m_state == 1));
        check("snoozing", 16'(snoozing), 16'(m_state == 2));
        check("alarm_id", 16'(alarm_id), 16'(m_id));
    endtask

    task automatic cycle();
        @(posedge clk);
        modelStep();
        #1;
        checkOutput();
        tick_seen += int'(tick);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // One cycle carrying the given pulse inputs, then all pulses cleared.
    task automatic applyStimulus(input bit sv, input int sh, input int sm, input int ss,
                                 input bit wr, input int idx, input int ah, input int am,
                                 input bit aen, input bit a, input bit sn);
        set_valid   = sv;
        set_hours   = 5'(sh);
        set_minutes = 6'(sm);
        set_seconds = 6'(ss);
        alm_wr      = wr;
        alm_idx     = IW'(idx);
        alm_hours   = 5'(ah);
        alm_minutes = 6'(am);
        alm_en      = aen;
        ack         = a;
        snooze      = sn;
        cycle();
        set_valid = 1'b0;
        alm_wr    = 1'b0;
        ack       = 1'b0;
        snooze    = 1'b0;
    endtask

    task automatic loadTime(input int h, input int m, input int s);
        applyStimulus(1'b1, h, m, s, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic writeSlot(input int idx, input int h, input int m, input bit en);
        applyStimulus(1'b0, 0, 0, 0, 1'b1, idx, h, m, en, 1'b0, 1'b0);
    endtask

    task automatic pressAck();
        applyStimulus(1'b0, 0, 0, 0, 1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic pressSnooze();
        applyStimulus(1'b0, 0, 0, 0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        modelReset();
        tick_seen = 0;

        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_hours", 16'(hours), 16'd0);
        check("rst_seconds", 16'(seconds), 16'd0);
        check("rst_alarm", 16'(alarm), 16'd0);
        check("rst_tick", 16'(tick), 16'd0);
        rst_n = 1'b1;
        idle(2);

        // 1: three ticks in 12 cycles, then freeze
        ena = 1'b1;
        tick_seen = 0;
        idle(12);
        check("t1_ticks", 16'(tick_seen), 16'd3);
        check("t1_sec", 16'(seconds), 16'd3);
        ena = 1'b0;
        idle(8);
        check("t1_hold", 16'(seconds), 16'd3);
        ena = 1'b1;

        // 2: midnight wrap, invalid load, load on an advance cycle
        loadTime(23, 59, 58);
        idle(8);
        check("t2_wrap_h", 16'(hours), 16'd0);
        check("t2_wrap_s", 16'(seconds), 16'd0);
        loadTime(24, 0, 0);
        check("t2_bad_h", 16'(hours), 16'd0);
        idle(2);
        loadTime(12, 34, 56);
        check("t2_load_tick", 16'(tick), 16'd0);
        check("t2_load_s", 16'(seconds), 16'd56);

        // 3: two slots on the same minute, lowest wins; loads never ring
        writeSlot(2, 7, 30, 1'b1);
        writeSlot(1, 7, 30, 1'b1);
        loadTime(7, 29, 59);
        idle(4);
        check("t3_alarm", 16'(alarm), 16'd1);
        check("t3_id", 16'(alarm_id), 16'd1);
        pressAck();
        loadTime(7, 30, 0);
        idle(4);
        check("t3_noring", 16'(alarm), 16'd0);

        // 4: snooze then re-ring at +5 minutes
        loadTime(7, 29, 59);
        idle(4);
        pressSnooze();
        check("t4_snz", 16'(snoozing), 16'd1);
        check("t4_alarm0", 16'(alarm), 16'd0);
        loadTime(7, 34, 58);
        idle(8);
        check("t4_rering", 16'(alarm), 16'd1);
        check("t4_id", 16'(alarm_id), 16'd1);
        pressAck();
        check("t4_ack", 16'(alarm | snoozing), 16'd0);

        // 5: auto-timeout after three seconds, ack beats snooze
        loadTime(7, 29, 59);
        idle(4);
        idle(11);
        check("t5_still", 16'(alarm), 16'd1);
        idle(1);
        check("t5_timeout", 16'(alarm), 16'd0);
        loadTime(7, 29, 59);
        idle(4);
        applyStimulus(1'b0, 0, 0, 0, 1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b1);
        check("t5_both_snz", 16'(snoozing), 16'd0);
        check("t5_both_alm", 16'(alarm), 16'd0);

        // 6: snooze across midnight, async reset mid-snooze
        writeSlot(0, 23, 58, 1'b1);
        loadTime(23, 57, 59);
        idle(4);
        check("t6_id", 16'(alarm_id), 16'd0);
        pressSnooze();
        loadTime(0, 2, 58);
        idle(8);
        check("t6_rering", 16'(alarm), 16'd1);
        check("t6_min", 16'(minutes), 16'd3);
        pressSnooze();
        idle(3);
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_rst_snz", 16'(snoozing), 16'd0);
        check("t6_rst_min", 16'(minutes), 16'd0);
        check("t6_rst_id", 16'(alarm_id), 16'd0);
        modelReset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        loadTime(23, 57, 59);
        idle(4);
        check("t6_slot0_off", 16'(alarm), 16'd0);
        loadTime(7, 29, 59);
        idle(4);
        check("t6_slot1_off", 16'(alarm), 16'd0);

        // Randomized phase around a few alarm minutes
        for (int n = 0; n < 600; n++) begin
            ena = ($urandom % 8) != 0;
            if ($urandom % 25 == 0)
                applyStimulus(1'b1, $urandom_range(0, 24), $urandom_range(0, 9),
                              $urandom_range(52, 60), 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
            else if ($urandom % 30 == 0)
                applyStimulus(1'b0, 0, 0, 0, 1'b1, $urandom_range(0, 3),
                              $urandom_range(0, 1) * 23, $urandom_range(0, 8),
                              1'($urandom), 1'b0, 1'b0);
            else
                applyStimulus(1'b0, 0, 0, 0, 1'b0, 0, 0, 0, 1'b0,
                              ($urandom % 25) == 0, ($urandom % 12) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/alarm_clock_multi.md
Name: alarm_clock_multi

Overview:
Parametrised successor to the single-alarm clock. Keeps a 24-hour HH:MM:SS time base driven from a divided system clock, which keeps running while an alarm rings. Holds NUM_ALARMS independently programmable and enabled alarms. A ring FSM supports acknowledge, snooze and auto-timeout. Sits between the clock tile and the display/buzzer logic.

Parameters:
CLK_DIV, 10, clk cycles per one-second tick (>=2; small values for simulation)
NUM_ALARMS, 4, number of alarm slots (>=1)
SNOOZE_MIN, 5, snooze length in minutes (1..59)
RING_TIMEOUT_S, 60, seconds of ringing before auto-stop (>=1)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
ena  input  1  prescaler enable; time freezes when low
set_valid  input  1  load time from set_* this cycle
set_hours  input  5  load value, 0..23
set_minutes  input  6  load value, 0..59
set_seconds  input  6  load value, 0..59
alm_wr  input  1  write alarm slot alm_idx
alm_idx  input  max(1,$clog2(NUM_ALARMS))  slot index
alm_hours  input  5  alarm hour, 0..23
alm_minutes  input  6  alarm minute, 0..59
alm_en  input  1  slot enable bit written with slot
ack  input  1  dismiss ring/snooze (level-sampled, one cycle)
snooze  input  1  request snooze while ringing
hours  output  5  current hour
minutes  output  6  current minute
seconds  output  6  current second
tick  output  1  one-cycle pulse on each second advance
alarm  output  1  high while in RINGING
alarm_id  output  max(1,$clog2(NUM_ALARMS))  slot that caused current ring/snooze
snoozing  output  1  high while in SNOOZE

Behaviour:
- Reset (async, rst_n low): hours/minutes/seconds=0, prescaler=0, tick=0, alarm=0, alarm_id=0, snoozing=0, FSM=IDLE, all slots cleared with enable=0. All outputs are registered.
- Prescaler: counts 0..CLK_DIV-1 while ena=1 and holds while ena=0. The advance occurs in the cycle the count equals CLK_DIV-1. tick is registered high the following cycle, coincident with the new time values.
- Time advance: seconds 59->0 carries to minutes; minutes 59->0 carries to hours; 23:59:59 -> 00:00:00.
- set_valid: has priority over the advance in the same cycle, clears the prescaler, and produces no tick. Any out-of-range field (hour >23, minute or second >59) causes the whole load to be ignored.
- alm_wr: writes the slot in one cycle. An out-of-range index, or out-of-range hour/minute, causes the write to be ignored. Writing a slot never affects an active ring.
- Match event: only on an advance whose new time has seconds==0. Set-time loads never trigger. An enabled slot matches when its hh:mm equals the new hh:mm. If several slots match, the lowest index wins.
- FSM states IDLE, RINGING, SNOOZE:
  - IDLE: on a match -> RINGING; alarm_id = slot index; ring second counter = 0.
  - RINGING: ack -> IDLE. Otherwise snooze -> SNOOZE, with target = current hh:mm + SNOOZE_MIN (minute wrap carries into hour; 23:5x wraps to 00). Otherwise, on each advance the ring counter increments; when it reaches RING_TIMEOUT_S -> IDLE.
  - SNOOZE: ack -> IDLE. Otherwise, on an advance whose new time is target hh:mm:00 -> RINGING, with the same alarm_id and ring counter cleared.
- Simultaneous events:
  - ack and snooze in the same cycle: ack wins.
  - Matches while in RINGING or SNOOZE are dropped, not queued.
  - A set_time load during SNOOZE leaves the target absolute.
  - ack while IDLE has no effect.
- Outputs: alarm = (state==RINGING); snoozing = (state==SNOOZE). Both update the cycle after the transition condition. alarm_id holds its value in IDLE.

Decomposition:
- Package alarm_clock_pkg holds:
  - ring FSM state enum;
  - constants MAX_HOUR=23, MAX_MIN=59, MAX_SEC=59;
  - a helper function that adds minutes with hour/day wrap.
- Natural sub-module: hms_counter. It contains the prescaler, the HH:MM:SS counter with load and validity check, and the tick/advance outputs. The top level holds the alarm slot registers, the priority match and the ring FSM.

Test Plan:
1. CLK_DIV=4. Reset, then ena=1 for 12 clk -> three tick pulses; time 00:00:03. With ena=0 for 8 clk -> time holds.
2. Load 23:59:58, run 2 ticks -> 23:59:59 then 00:00:00. Load 24:00:00 -> ignored, time unchanged. set_valid on an advance cycle -> load wins, no tick.
3. Slot 2 = 07:30 and slot 1 = 07:30, both enabled. Load 07:29:59, one tick -> alarm=1, alarm_id=1. Load 07:30:00 directly (no ring active) -> no alarm.
4. Ringing at 07:30 with SNOOZE_MIN=5. Assert snooze -> snoozing=1, alarm=0. Advance to 07:35:00 -> alarm=1, alarm_id unchanged. Assert ack -> IDLE, both outputs 0.
5. Ringing with RING_TIMEOUT_S=3, no ack -> alarm falls 3 ticks after rising. ack+snooze in the same cycle -> IDLE, snoozing stays 0.
6. Slot 0 = 23:58, snooze at 23:58 -> ring again at 00:03:00. Assert rst_n low mid-snooze -> all outputs 0 asynchronously, slots disabled.
